// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand-conditioning blocks: the serial
// negate FSM state encoding, the default operand width and the
// most-negative operand pattern at that width.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 32;

  // Only the MSB set: the one operand whose negation overflows.
  localparam logic [DEFAULT_WIDTH-1:0] MOST_NEG = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

endpackage : alu_pkg

// File: rtl/neg_bit_cell.sv
// Per-bit rule for serial complement / two's-complement negation.
// mode=0: every bit is inverted.
// mode=1: bits are copied up to and including the first 1, then inverted.
module neg_bit_cell (
  input  logic b,
  input  logic mode,
  input  logic seen_one,
  output logic r,
  output logic seen_one_next
);

  // Copy while negating and no 1 has been seen yet; otherwise invert.
  assign r             = (mode && !seen_one) ? b : ~b;
  assign seen_one_next = seen_one | b;

endmodule : neg_bit_cell

// File: rtl/serial_negate_32bit.sv
// Bit-serial operand conditioner for the ALU subtract path. Consumes one
// operand bit per clock, LSB first, and returns either the bitwise
// complement (in_neg=0) or the two's-complement negation (in_neg=1).
// Valid/ready handshakes on both sides; one operand in flight at a time.
//
// Optional build macro SERIAL_NEG_ZERO_FLAG_EN adds out_zero, set when the
// result is all zeros (accumulated serially as the bits are produced).
module serial_negate_32bit
  import alu_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
`ifdef SERIAL_NEG_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] result_q;
  logic             mode_q;
  logic             seen_one_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_pend_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_ovf_q;

  logic             bit_r_d;
  logic             seen_one_d;

  // One shared cell evaluates the current LSB every SHIFT cycle.
  neg_bit_cell u_cell (
    .b             (shreg_q[0]),
    .mode          (mode_q),
    .seen_one      (seen_one_q),
    .r             (bit_r_d),
    .seen_one_next (seen_one_d)
  );

  // Ready only while idle; held low for the whole reset cycle so nothing
  // is accepted on the edge that reset is being applied.
  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

`ifdef SERIAL_NEG_ZERO_FLAG_EN
  logic zero_acc_q;
  logic out_zero_q;

  assign out_zero = out_zero_q;

  // OR-accumulate produced bits; latched inverted alongside out_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_acc_q <= 1'b0;
      out_zero_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE:    if (in_valid) zero_acc_q <= 1'b0;
        SHIFT:   zero_acc_q <= zero_acc_q | bit_r_d;
        DONE:    if (!out_valid_q) out_zero_q <= ~zero_acc_q;
        default: ;
      endcase
    end
  end
`endif

  // Control FSM plus shift datapath and registered handshake outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      result_q    <= '0;
      mode_q      <= 1'b0;
      seen_one_q  <= 1'b0;
      cnt_q       <= '0;
      ovf_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // in_ready is simply "idle and not in reset" here.
          if (in_valid) begin
            shreg_q    <= in_data;
            mode_q     <= in_neg;
            seen_one_q <= 1'b0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end

        SHIFT: begin
          shreg_q    <= shreg_q >> 1;
          result_q   <= {bit_r_d, result_q[WIDTH-1:1]};
          seen_one_q <= seen_one_d;
          cnt_q      <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            // First 1 arriving on the MSB means the operand was MOST_NEG.
            ovf_pend_q <= mode_q && shreg_q[0] && !seen_one_q;
            state_q    <= DONE;
          end
        end

        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= result_q;
            out_ovf_q   <= ovf_pend_q;
          end else if (out_ready) begin
            // out_data/out_ovf keep their last values after the handshake.
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule : serial_negate_32bit

// File: tb/tb_serial_negate_32bit.sv
// Directed bench for serial_negate_32bit at the default 32-bit width.
module tb_serial_negate_32bit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_neg;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
`ifdef SERIAL_NEG_ZERO_FLAG_EN
  logic        out_zero;
`endif

  int errors = 0;
  int checks = 0;

  serial_negate_32bit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_neg    (in_neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
`ifdef SERIAL_NEG_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; drive and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid, counting edges since the accepting edge.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
  endtask

  // Full transaction with out_ready held high throughout.
  task automatic run_op(input string tag, input logic [31:0] d, input logic neg,
                        input logic [31:0] exp_d, input logic exp_ovf);
    int n;
    in_data   = d;
    in_neg    = neg;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    check({tag, "_busy"}, 64'(in_ready), 64'(0));
    wait_valid(n);
    check({tag, "_latency"}, 64'(n), 64'(33));
    check({tag, "_data"}, 64'(out_data), 64'(exp_d));
    check({tag, "_ovf"}, 64'(out_ovf), 64'(exp_ovf));
`ifdef SERIAL_NEG_ZERO_FLAG_EN
    check({tag, "_zero"}, 64'(out_zero), 64'(exp_d == 32'd0));
`endif
    step();
    check({tag, "_valid_drop"}, 64'(out_valid), 64'(0));
    check({tag, "_ready_back"}, 64'(in_ready), 64'(1));
    check({tag, "_data_kept"}, 64'(out_data), 64'(exp_d));
  endtask

  initial begin
    int n;
    logic [31:0] held;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_neg    = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_in_ready_during", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    reset = 1'b0;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'(1));
    check("idle_out_valid", 64'(out_valid), 64'(0));
    check("idle_out_data", 64'(out_data), 64'(0));
    check("idle_out_ovf", 64'(out_ovf), 64'(0));

    run_op("neg5",    32'h0000_0005, 1'b1, 32'hFFFF_FFFB, 1'b0);
    run_op("inv",     32'h0F0F_00FF, 1'b0, 32'hF0F0_FF00, 1'b0);
    run_op("negones", 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 1'b0);
    run_op("negzero", 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0);
    run_op("invzero", 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0);
    run_op("negmin",  32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1);

    // Reset during SHIFT cycle 12 discards the partial result.
    in_data  = 32'h0000_1234;
    in_neg   = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("midrst_busy", 64'(in_ready), 64'(0));
    reset = 1'b1;
    step();
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_out_data", 64'(out_data), 64'(0));
    check("midrst_out_ovf", 64'(out_ovf), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(0));
    reset = 1'b0;
    #1;
    run_op("postrst", 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0);

    // Backpressure: result held while a second operand waits.
    in_data   = 32'h0000_0003;
    in_neg    = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_data = 32'h0000_0010;
    wait_valid(n);
    check("bp_latency", 64'(n), 64'(33));
    check("bp_data", 64'(out_data), 64'(32'hFFFF_FFFD));
    held = 32'hFFFF_FFFD;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_data", 64'(out_data), 64'(held));
      check("bp_hold_valid", 64'(out_valid), 64'(1));
      check("bp_hold_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    step();
    check("bp_hs_valid_drop", 64'(out_valid), 64'(0));
    check("bp_hs_in_ready", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    check("bp_second_accepted", 64'(in_ready), 64'(0));
    wait_valid(n);
    check("bp2_latency", 64'(n), 64'(33));
    check("bp2_data", 64'(out_data), 64'(32'hFFFF_FFF0));
    check("bp2_ovf", 64'(out_ovf), 64'(0));
    step();
    check("bp2_valid_drop", 64'(out_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_negate_32bit
